// File: rtl/calc_pkg.sv
// Shared calculator definitions.
// - state_e      : four-phase sequencer states. The divider FSM and later
//                  operation sequencers use the same states.
// - DEF_W        : default operand width.
// - calc_timeout : watchdog limit for a W-bit divide. The worst case is a
//                  2^W iteration divide plus a small margin.
package calc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int unsigned DEF_W = 8;

  function automatic int unsigned calc_timeout(input int unsigned w);
    return (32'd1 << w) + 32'd4;
  endfunction

endpackage

// File: rtl/div_requester_if.sv
// Handshake bundle around div_requester.
// - cmd_* : command from the front end (valid/ready, operands).
// - start/op_*/div_* : start/ready handshake with the divider core.
// - div_abort : watchdog pulse. The parent ORs it into the core reset.
// - res_* : held result toward the consumer, released by res_ack.
// modport master : the requester.
// modport slave  : the environment (front end, core and consumer).
interface div_requester_if #(
  parameter int unsigned W = 8
);
  logic         cmd_valid;
  logic         cmd_ready;
  logic [W-1:0] cmd_a;
  logic [W-1:0] cmd_b;

  logic         start;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         div_ready;
  logic         div_error;
  logic [W-1:0] div_q;
  logic [W-1:0] div_r;
  logic         div_abort;

  logic         res_valid;
  logic         res_ack;
  logic [W-1:0] res_q;
  logic [W-1:0] res_r;
  logic         res_err;
  logic         res_timeout;

  modport master (
    input  cmd_valid, cmd_a, cmd_b,
    input  div_ready, div_error, div_q, div_r,
    input  res_ack,
    output cmd_ready, start, op_a, op_b, div_abort,
    output res_valid, res_q, res_r, res_err, res_timeout
  );

  modport slave (
    output cmd_valid, cmd_a, cmd_b,
    output div_ready, div_error, div_q, div_r,
    output res_ack,
    input  cmd_ready, start, op_a, op_b, div_abort,
    input  res_valid, res_q, res_r, res_err, res_timeout
  );

endinterface

// File: rtl/div_requester_timer.sv
// cycle_timer: saturating up-counter with clear and enable.
// - clk, reset : clock and synchronous active-high reset.
// - clr        : force the count to zero. Takes priority over en.
// - en         : advance the count by one. The count sticks at all-ones.
// - hit        : count equals TERMINAL.
module cycle_timer #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned TERMINAL = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic hit
);

  localparam logic [WIDTH-1:0] TERM = WIDTH'(TERMINAL);
  localparam logic [WIDTH-1:0] SAT  = {WIDTH{1'b1}};

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (en && cnt_q != SAT)
      cnt_d = cnt_q + WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign hit = (cnt_q == TERM);

endmodule

// File: rtl/div_requester.sv
// div_requester: initiator side of the divider start/ready handshake.
// - clk, reset : clock and synchronous active-high reset. The core shares
//                this reset.
// - bus        : div_requester_if.master.
//                cmd_*     : command in.
//                start/op_*: drive the core.
//                div_*     : core result in.
//                div_abort : watchdog pulse out.
//                res_*     : held result, released by res_ack.
// Flow: IDLE accepts a command -> ISSUE pulses start -> WAIT for div_ready
// or the watchdog -> DONE holds the result until res_ack.
// cmd_ready and start decode the state. Every other output is a flop.
module div_requester
  import calc_pkg::*;
#(
  parameter int unsigned W       = DEF_W,
  parameter int unsigned TIMEOUT = calc_timeout(W)
) (
  input  logic            clk,
  input  logic            reset,
  div_requester_if.master bus
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  state_e       state_q, state_d;
  logic [W-1:0] op_a_q, op_a_d;
  logic [W-1:0] op_b_q, op_b_d;
  logic [W-1:0] res_q_q, res_q_d;
  logic [W-1:0] res_r_q, res_r_d;
  logic         res_err_q, res_err_d;
  logic         res_timeout_q, res_timeout_d;
  logic         res_valid_q, res_valid_d;
  logic         div_abort_q, div_abort_d;

  logic tmr_clr, tmr_en, tmr_hit;

  // The timer counts WAIT cycles from zero. It hits on the TIMEOUT-th WAIT
  // cycle (count TIMEOUT-1).
  cycle_timer #(
    .WIDTH    (TW),
    .TERMINAL (TIMEOUT - 1)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .clr   (tmr_clr),
    .en    (tmr_en),
    .hit   (tmr_hit)
  );

  always_comb begin
    state_d       = state_q;
    op_a_d        = op_a_q;
    op_b_d        = op_b_q;
    res_q_d       = res_q_q;
    res_r_d       = res_r_q;
    res_err_d     = res_err_q;
    res_timeout_d = res_timeout_q;
    res_valid_d   = res_valid_q;
    div_abort_d   = 1'b0;
    tmr_clr       = 1'b0;
    tmr_en        = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          op_a_d        = bus.cmd_a;
          op_b_d        = bus.cmd_b;
          res_err_d     = 1'b0;
          res_timeout_d = 1'b0;
          state_d       = ISSUE;
        end
      end

      ISSUE: begin
        // The core is idle here. A divide-by-zero can complete in this
        // same cycle.
        if (bus.div_ready) begin
          res_q_d     = bus.div_q;
          res_r_d     = bus.div_r;
          res_err_d   = bus.div_error;
          res_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          tmr_clr = 1'b1;
          state_d = WAIT;
        end
      end

      WAIT: begin
        tmr_en = 1'b1;
        // A completion in the watchdog's last cycle wins over the abort.
        if (bus.div_ready) begin
          res_q_d     = bus.div_q;
          res_r_d     = bus.div_r;
          res_err_d   = bus.div_error;
          res_valid_d = 1'b1;
          state_d     = DONE;
        end else if (tmr_hit) begin
          res_q_d       = '0;
          res_r_d       = '0;
          res_err_d     = 1'b0;
          res_timeout_d = 1'b1;
          div_abort_d   = 1'b1;
          res_valid_d   = 1'b1;
          state_d       = DONE;
        end
      end

      DONE: begin
        if (bus.res_ack) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      op_a_q        <= '0;
      op_b_q        <= '0;
      res_q_q       <= '0;
      res_r_q       <= '0;
      res_err_q     <= 1'b0;
      res_timeout_q <= 1'b0;
      res_valid_q   <= 1'b0;
      div_abort_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      op_a_q        <= op_a_d;
      op_b_q        <= op_b_d;
      res_q_q       <= res_q_d;
      res_r_q       <= res_r_d;
      res_err_q     <= res_err_d;
      res_timeout_q <= res_timeout_d;
      res_valid_q   <= res_valid_d;
      div_abort_q   <= div_abort_d;
    end
  end

  assign bus.cmd_ready   = (state_q == IDLE);
  assign bus.start       = (state_q == ISSUE);
  assign bus.op_a        = op_a_q;
  assign bus.op_b        = op_b_q;
  assign bus.div_abort   = div_abort_q;
  assign bus.res_valid   = res_valid_q;
  assign bus.res_q       = res_q_q;
  assign bus.res_r       = res_r_q;
  assign bus.res_err     = res_err_q;
  assign bus.res_timeout = res_timeout_q;

endmodule

// File: tb/tb_div_requester.sv
module tb_div_requester;
  import calc_pkg::*;

  localparam int W  = 8;
  localparam int TO = 16;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         err;
    logic         tout;
    int           k;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  div_requester_if #(.W(W)) bus ();

  div_requester #(.W(W), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic core_idle();
    bus.div_ready = 1'b0;
    bus.div_error = 1'b0;
    bus.div_q     = 8'hAA;
    bus.div_r     = 8'h55;
  endtask

  // One transaction. lat is the cycle after the start cycle in which the
  // core model raises div_ready. A negative lat means the core never
  // answers.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int lat, input bit hold_valid,
                        input logic [W-1:0] eq, input logic [W-1:0] er,
                        input bit eerr, input bit etout);
    exp_t e, g;
    int   k_obs, n_start, n_abort, w;
    bit   op_bad, hold_bad;
    w = 0;
    while (bus.cmd_ready !== 1'b1 && w < 40) begin tick(); w++; end
    n_cmp++;
    if (bus.cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL %s cmd_ready: got %b want 1", tag, bus.cmd_ready);
    end
    e.q = eq; e.r = er; e.err = eerr; e.tout = etout;
    e.k = etout ? TO + 1 : lat + 1;
    bus.cmd_valid = 1'b1; bus.cmd_a = a; bus.cmd_b = b;
    sb.push_back(e);
    tick();
    if (!hold_valid) bus.cmd_valid = 1'b0;
    n_start = 0; n_abort = 0; k_obs = -1; op_bad = 1'b0;
    for (int k = 0; k < TO + 8; k++) begin
      n_start += int'(bus.start);
      n_abort += int'(bus.div_abort);
      if (bus.res_valid === 1'b1) begin k_obs = k; break; end
      if (bus.op_a !== a || bus.op_b !== b) op_bad = 1'b1;
      if (k == lat) begin
        bus.div_ready = 1'b1;
        bus.div_error = (b == 0);
        bus.div_q     = (b == 0) ? 8'hFF : a / b;
        bus.div_r     = (b == 0) ? a : a % b;
      end else core_idle();
      tick();
    end
    core_idle();
    n_cmp++;
    if (op_bad) begin
      n_fail++; $display("FAIL %s op_stable: got a=%0d b=%0d want a=%0d b=%0d", tag, bus.op_a, bus.op_b, a, b);
    end
    if (sb.size() == 0) begin
      n_cmp++; n_fail++; $display("FAIL %s scoreboard: got empty want 1 entry", tag);
      return;
    end
    g = sb.pop_front();
    n_cmp++;
    if (k_obs !== g.k) begin
      n_fail++; $display("FAIL %s res_valid_cycle: got %0d want %0d", tag, k_obs, g.k);
    end
    if (k_obs < 0) return;
    n_cmp++;
    if (bus.res_q !== g.q) begin n_fail++; $display("FAIL %s res_q: got %0d want %0d", tag, bus.res_q, g.q); end
    n_cmp++;
    if (bus.res_r !== g.r) begin n_fail++; $display("FAIL %s res_r: got %0d want %0d", tag, bus.res_r, g.r); end
    n_cmp++;
    if (bus.res_err !== g.err) begin n_fail++; $display("FAIL %s res_err: got %b want %b", tag, bus.res_err, g.err); end
    n_cmp++;
    if (bus.res_timeout !== g.tout) begin n_fail++; $display("FAIL %s res_timeout: got %b want %b", tag, bus.res_timeout, g.tout); end
    // Hold the result without an ack. A stray div_ready must not disturb it.
    hold_bad = 1'b0;
    for (int h = 0; h < 3; h++) begin
      if (h == 1) begin
        bus.div_ready = 1'b1; bus.div_error = 1'b1; bus.div_q = 8'h77; bus.div_r = 8'h66;
      end else core_idle();
      tick();
      n_start += int'(bus.start);
      n_abort += int'(bus.div_abort);
      if (bus.res_valid !== 1'b1 || bus.res_q !== g.q || bus.res_r !== g.r ||
          bus.res_err !== g.err || bus.cmd_ready !== 1'b0) hold_bad = 1'b1;
    end
    core_idle();
    n_cmp++;
    if (hold_bad) begin
      n_fail++; $display("FAIL %s hold: got v=%b q=%0d r=%0d e=%b want v=1 q=%0d r=%0d e=%b", tag,
                         bus.res_valid, bus.res_q, bus.res_r, bus.res_err, g.q, g.r, g.err);
    end
    n_cmp++;
    if (n_start !== 1) begin n_fail++; $display("FAIL %s start_count: got %0d want 1", tag, n_start); end
    n_cmp++;
    if (n_abort !== int'(etout)) begin n_fail++; $display("FAIL %s abort_count: got %0d want %0d", tag, n_abort, int'(etout)); end
    // Ack cycle: still DONE, no accept possible.
    bus.res_ack = 1'b1;
    n_cmp++;
    if (bus.cmd_ready !== 1'b0 || bus.start !== 1'b0) begin
      n_fail++; $display("FAIL %s ack_cycle: got rdy=%b start=%b want 0 0", tag, bus.cmd_ready, bus.start);
    end
    tick();
    bus.res_ack = 1'b0;
    n_cmp++;
    if (bus.cmd_ready !== 1'b1 || bus.res_valid !== 1'b0 || bus.start !== 1'b0) begin
      n_fail++; $display("FAIL %s after_ack: got rdy=%b v=%b start=%b want 1 0 0", tag,
                         bus.cmd_ready, bus.res_valid, bus.start);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    n_cmp++;
    if (bus.cmd_ready !== 1'b1 || bus.start !== 1'b0 || bus.div_abort !== 1'b0 ||
        bus.res_valid !== 1'b0 || bus.res_err !== 1'b0 || bus.res_timeout !== 1'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got rdy=%b st=%b ab=%b v=%b e=%b t=%b want 1 0 0 0 0 0",
                         bus.cmd_ready, bus.start, bus.div_abort, bus.res_valid, bus.res_err, bus.res_timeout);
    end
    n_cmp++;
    if (bus.op_a !== 8'd0 || bus.op_b !== 8'd0 || bus.res_q !== 8'd0 || bus.res_r !== 8'd0) begin
      n_fail++; $display("FAIL reset_data: got %0d %0d %0d %0d want 0 0 0 0", bus.op_a, bus.op_b, bus.res_q, bus.res_r);
    end
  endtask

  task automatic test_basic();
    run_op("basic_100_7", 8'd100, 8'd7, 4, 1'b0, 8'd14, 8'd2, 1'b0, 1'b0);
  endtask

  task automatic test_div_zero();
    run_op("div_zero", 8'd5, 8'd0, 0, 1'b0, 8'hFF, 8'd5, 1'b1, 1'b0);
  endtask

  task automatic test_boundary();
    run_op("a_lt_b", 8'd3, 8'd9, 2, 1'b0, 8'd0, 8'd3, 1'b0, 1'b0);
    run_op("b_one", 8'd255, 8'd1, 9, 1'b0, 8'd255, 8'd0, 1'b0, 1'b0);
  endtask

  task automatic test_timeout();
    run_op("timeout", 8'd42, 8'd5, -1, 1'b0, 8'd0, 8'd0, 1'b0, 1'b1);
    run_op("timeout_race", 8'd42, 8'd5, TO, 1'b0, 8'd8, 8'd2, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_op("b2b_first", 8'd77, 8'd10, 3, 1'b1, 8'd7, 8'd7, 1'b0, 1'b0);
    run_op("b2b_second", 8'd200, 8'd13, 5, 1'b1, 8'd15, 8'd5, 1'b0, 1'b0);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    bus.cmd_valid = 1'b1; bus.cmd_a = 8'd50; bus.cmd_b = 8'd5;
    tick();
    bus.cmd_valid = 1'b0;
    tick(); tick(); tick();
    n_cmp++;
    if (bus.start !== 1'b0 || bus.cmd_ready !== 1'b0 || bus.res_valid !== 1'b0) begin
      n_fail++; $display("FAIL mid_wait: got st=%b rdy=%b v=%b want 0 0 0", bus.start, bus.cmd_ready, bus.res_valid);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_cmp++;
    if (bus.cmd_ready !== 1'b1 || bus.res_valid !== 1'b0 || bus.start !== 1'b0 ||
        bus.op_a !== 8'd0 || bus.res_timeout !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset: got rdy=%b v=%b st=%b op_a=%0d t=%b want 1 0 0 0 0",
                         bus.cmd_ready, bus.res_valid, bus.start, bus.op_a, bus.res_timeout);
    end
    run_op("after_reset", 8'd20, 8'd6, 3, 1'b0, 8'd3, 8'd2, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_a = '0; bus.cmd_b = '0;
    bus.res_ack = 1'b0;
    core_idle();
    test_reset();
    test_basic();
    test_div_zero();
    test_boundary();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
